alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request and result handshake.
// Single-cycle ops finish in one edge; MUL runs a WIDTH-cycle shift-add.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [4:0]       op_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] alu_o,
  output logic             err_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SLL = 5'd2;
  localparam logic [4:0] OP_SRL = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_EQL = 5'd7;
  localparam logic [4:0] OP_SRA = 5'd8;
  localparam logic [4:0] OP_MUL = 5'd9;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_n;
  logic [WIDTH-1:0]   alu_q;
  logic               err_q;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   res;
  logic               illegal;
  logic [SHAMT_W-1:0] sh;

  assign sh     = b_i[SHAMT_W-1:0];
  assign is_mul = (op_i == OP_MUL);
  assign accept = valid_i & ready_o;
  assign acc_n  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op_i)
      OP_ADD:  res = a_i + b_i;
      OP_SUB:  res = a_i - b_i;
      OP_SLL:  res = a_i << sh;
      OP_SRL:  res = a_i >> sh;
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_EQL:  res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_SRA:  res = WIDTH'($signed(a_i) >>> sh);
      OP_MUL:  res = '0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_n = is_mul ? MUL : DONE;
      end
      MUL: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) begin
          if (valid_i) state_n = is_mul ? MUL : DONE;
          else         state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      alu_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= a_i;
        mplier <= b_i;
        acc    <= '0;
        cnt    <= CW'(WIDTH-1);
      end else begin
        alu_q <= res;
        err_q <= illegal;
      end
    end else if (state == MUL) begin
      // multiplicand walks left while multiplier bits are consumed LSB first
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == '0) begin
        alu_q <= acc_n;
        err_q <= 1'b0;
      end
    end
  end

  assign alu_o = alu_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32.
// Inputs change #1 after the rising edge, outputs sampled there too.
module tb_alu_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [4:0]  op_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] alu_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i    (a_i),
    .b_i    (b_i),
    .op_i   (op_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .alu_o  (alu_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (valid_o !== 1'b0 || alu_o !== 32'h0 || err_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset v=%b alu=%h err=%b rdy=%b want 0 0 0 1", valid_o, alu_o, err_o, ready_o);
    end
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_add_wrap();
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i = 5'd0;
    a_i = 32'hFFFF_FFFF;
    b_i = 32'h1;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'h0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap v=%b alu=%h err=%b want 1 00000000 0", valid_o, alu_o, err_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL add_idle v=%b rdy=%b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i = 5'd8;
    a_i = 32'h8000_0000;
    b_i = 32'd4;
    tick();
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'hF800_0000 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL sra_b2b v=%b alu=%h rdy=%b want 1 f8000000 1", valid_o, alu_o, ready_o);
    end
    op_i = 5'd3;
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl_b2b v=%b alu=%h want 1 08000000", valid_o, alu_o);
    end
    tick();
  endtask

  task automatic test_ops();
    logic [4:0]  ops [10];
    logic [31:0] as  [10];
    logic [31:0] bs  [10];
    logic [31:0] exp [10];
    ops[0] = 5'd1; as[0] = 32'h0;         bs[0] = 32'h1;         exp[0] = 32'hFFFF_FFFF;
    ops[1] = 5'd2; as[1] = 32'h1;         bs[1] = 32'h3F;        exp[1] = 32'h8000_0000;
    ops[2] = 5'd2; as[2] = 32'h8000_0001; bs[2] = 32'h21;        exp[2] = 32'h0000_0002;
    ops[3] = 5'd3; as[3] = 32'hF000_0000; bs[3] = 32'd31;        exp[3] = 32'h0000_0001;
    ops[4] = 5'd4; as[4] = 32'hFF00_FF00; bs[4] = 32'h0FF0_0FF0; exp[4] = 32'h0F00_0F00;
    ops[5] = 5'd5; as[5] = 32'hFF00_FF00; bs[5] = 32'h0FF0_0FF0; exp[5] = 32'hFFF0_FFF0;
    ops[6] = 5'd6; as[6] = 32'hFF00_FF00; bs[6] = 32'h0FF0_0FF0; exp[6] = 32'hF0F0_F0F0;
    ops[7] = 5'd7; as[7] = 32'h1234;      bs[7] = 32'h1235;      exp[7] = 32'h0;
    ops[8] = 5'd8; as[8] = 32'h7000_0000; bs[8] = 32'd4;         exp[8] = 32'h0700_0000;
    ops[9] = 5'd8; as[9] = 32'hFFFF_FFF0; bs[9] = 32'd31;        exp[9] = 32'hFFFF_FFFF;
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op_i = ops[i];
      a_i = as[i];
      b_i = bs[i];
      tick();
      checks++;
      if (valid_o !== 1'b1 || alu_o !== exp[i] || err_o !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_vec%0d v=%b alu=%h err=%b want 1 %h 0", ops[i], i, valid_o, alu_o, err_o, exp[i]);
      end
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    logic [4:0] bad [3];
    bad[0] = 5'd15;
    bad[1] = 5'd10;
    bad[2] = 5'd31;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      op_i = 5'd0;
      a_i = 32'h5;
      b_i = 32'h6;
      tick();
      op_i = bad[i];
      tick();
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b1 || alu_o !== 32'h0 || err_o !== 1'b1) begin
        errors++;
        $display("FAIL illegal%0d v=%b alu=%h err=%b want 1 0 1", bad[i], valid_o, alu_o, err_o);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    logic [31:0] ma [3];
    logic [31:0] mb [3];
    logic [31:0] me [3];
    int bad_wait;
    ma[0] = 32'h0001_0001; mb[0] = 32'h0001_0001; me[0] = 32'h0002_0001;
    ma[1] = 32'hFFFF_FFFF; mb[1] = 32'hFFFF_FFFF; me[1] = 32'h0000_0001;
    ma[2] = 32'd7;         mb[2] = 32'd6;         me[2] = 32'd42;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      op_i = 5'd9;
      a_i = ma[i];
      b_i = mb[i];
      tick();
      // a pending ADD must wait out the multiply
      op_i = 5'd0;
      a_i = 32'd2;
      b_i = 32'd3;
      bad_wait = 0;
      for (int c = 0; c < 32; c++) begin
        if (ready_o !== 1'b0 || valid_o !== 1'b0) bad_wait++;
        tick();
      end
      checks++;
      if (bad_wait != 0) begin
        errors++;
        $display("FAIL mul_busy%0d bad_cycles=%0d want 0", i, bad_wait);
      end
      checks++;
      if (valid_o !== 1'b1 || alu_o !== me[i] || err_o !== 1'b0) begin
        errors++;
        $display("FAIL mul%0d v=%b alu=%h err=%b want 1 %h 0", i, valid_o, alu_o, err_o, me[i]);
      end
      tick();
      valid_i = 1'b0;
      checks++;
      if (valid_o !== 1'b1 || alu_o !== 32'd5) begin
        errors++;
        $display("FAIL mul_held_req%0d v=%b alu=%h want 1 00000005", i, valid_o, alu_o);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int moved;
    ready_i = 1'b0;
    valid_i = 1'b1;
    op_i = 5'd7;
    a_i = 32'h1234;
    b_i = 32'h1234;
    tick();
    valid_i = 1'b0;
    a_i = 32'h0;
    moved = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid_o !== 1'b1 || alu_o !== 32'h1 || ready_o !== 1'b0) moved++;
      tick();
    end
    checks++;
    if (moved != 0) begin
      errors++;
      $display("FAIL eql_stall bad_cycles=%0d want 0", moved);
    end
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'h1) begin
      errors++;
      $display("FAIL eql_hold v=%b alu=%h want 1 00000001", valid_o, alu_o);
    end
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL eql_idle v=%b rdy=%b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset_mul();
    int ghost;
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i = 5'd0;
    a_i = 32'h1111;
    b_i = 32'h2222;
    tick();
    op_i = 5'd9;
    a_i = 32'd3;
    b_i = 32'd5;
    tick();
    valid_i = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (alu_o !== 32'h3333 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset v=%b alu=%h want 0 00003333", valid_o, alu_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || alu_o !== 32'h0 || err_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL async_reset v=%b alu=%h err=%b rdy=%b want 0 0 0 1", valid_o, alu_o, err_o, ready_o);
    end
    #1;
    rst_ni = 1'b1;
    ghost = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (valid_o !== 1'b0 || alu_o !== 32'h0) ghost++;
    end
    checks++;
    if (ghost != 0) begin
      errors++;
      $display("FAIL reset_discard ghost_cycles=%0d want 0", ghost);
    end
    valid_i = 1'b1;
    op_i = 5'd9;
    a_i = 32'd3;
    b_i = 32'd5;
    tick();
    valid_i = 1'b0;
    for (int c = 0; c < 32; c++) tick();
    checks++;
    if (valid_o !== 1'b1 || alu_o !== 32'd15) begin
      errors++;
      $display("FAIL mul_after_reset v=%b alu=%h want 1 0000000f", valid_o, alu_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_ops();
    test_illegal();
    test_mul();
    test_stall();
    test_reset_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
